// File: rtl/bcd2bin_arbiter_pkg.sv
// Shared types and default sizes for the BCD-to-binary converter arbiter.
// Import this package in every file of the block.
package bcd2bin_arb_pkg;
    localparam int N_REQ_DEF   = 4;
    localparam int BCD_W_DEF   = 12;
    localparam int BIN_W_DEF   = 10;
    localparam int TIMEOUT_DEF = 63;
    localparam int ID_W_DEF    = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACK   = 3'd3,
        ST_ERR   = 3'd4
    } state_t;
endpackage

// File: rtl/bcd2bin_arbiter_if.sv
// Bundles the requester and converter signals of the arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the converter.
interface bcd2bin_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int BCD_W = 12,
    parameter int BIN_W = 10,
    parameter int ID_W  = 2
);
    import bcd2bin_arb_pkg::*;

    // Handshake: req[i] is a one-cycle pulse that queues requester i, and
    // bcd_in slice i must stay stable until that requester sees ack[i] or err[i].
    // Each of ack and err is a one-hot, one-cycle pulse. cv_init is a one-cycle
    // start pulse to the converter. The converter answers with a one-cycle
    // cv_done, and cv_bin is valid in that same cycle.
    logic [N_REQ-1:0]       req;
    logic [N_REQ*BCD_W-1:0] bcd_in;
    logic [N_REQ-1:0]       ack;
    logic [N_REQ-1:0]       err;
    logic [BIN_W-1:0]       bin_out;
    logic [ID_W-1:0]        grant_id;
    logic                   busy;
    logic                   cv_init;
    logic [BCD_W-1:0]       cv_bcd;
    logic                   cv_done;
    logic [BIN_W-1:0]       cv_bin;
    state_t                 dbg_state;

    modport slave (
        input  req, bcd_in, cv_done, cv_bin,
        output ack, err, bin_out, grant_id, busy, cv_init, cv_bcd, dbg_state
    );

    modport master (
        output req, bcd_in, cv_done, cv_bin,
        input  ack, err, bin_out, grant_id, busy, cv_init, cv_bcd, dbg_state
    );
endinterface

// File: rtl/bcd2bin_arbiter_rr_picker.sv
// Round-robin priority encoder: first set pending bit at or above rr_ptr, wrapping.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] pending_i,
    input  logic [ID_W-1:0]  rr_ptr_i,
    output logic [ID_W-1:0]  pick_o,
    output logic             any_o
);
    int idx;

    // Scan from the farthest candidate down, so the one nearest rr_ptr is written last.
    always_comb begin
        pick_o = '0;
        any_o  = 1'b0;
        idx    = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_i) + k) % N_REQ;
            if (pending_i[idx]) begin
                pick_o = ID_W'(idx);
                any_o  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bcd2bin_arbiter.sv
// Shares one BCD-to-binary converter among N_REQ requesters. Requests are queued
// and picked round-robin, and each transaction is bounded by a wait watchdog.
module bcd2bin_arbiter
    import bcd2bin_arb_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int BCD_W   = BCD_W_DEF,
    parameter int BIN_W   = BIN_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int ID_W    = ID_W_DEF
) (
    input logic clk,
    input logic rst,
    bcd2bin_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [BCD_W-1:0] cv_bcd_q, cv_bcd_d;
    logic [BIN_W-1:0] bin_q, bin_d;

    logic [ID_W-1:0]  pick;
    logic             any;
    logic [N_REQ-1:0] grant_oh;
    logic [N_REQ-1:0] ack_w, err_w;
    logic             cv_init_w;
    logic [ID_W-1:0]  next_ptr;

    rr_picker #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr_picker (
        .pending_i (pending_q),
        .rr_ptr_i  (rr_ptr_q),
        .pick_o    (pick),
        .any_o     (any)
    );

    assign grant_oh = N_REQ'(1) << grant_q;
    assign next_ptr = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        wait_cnt_d = wait_cnt_q;
        grant_d    = grant_q;
        cv_bcd_d   = cv_bcd_q;
        bin_d      = bin_q;
        ack_w      = '0;
        err_w      = '0;
        cv_init_w  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    grant_d  = pick;
                    cv_bcd_d = bus.bcd_in[int'(pick)*BCD_W +: BCD_W];
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                cv_init_w  = 1'b1;
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving on the last allowed cycle still counts as success.
                if (bus.cv_done) begin
                    bin_d   = bus.cv_bin;
                    state_d = ST_ACK;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d = ST_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_ACK: begin
                ack_w    = grant_oh;
                rr_ptr_d = next_ptr;
                state_d  = ST_IDLE;
            end
            ST_ERR: begin
                err_w    = grant_oh;
                rr_ptr_d = next_ptr;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A new pulse in the completion cycle re-queues the requester.
        pending_d = (pending_q & ~(ack_w | err_w)) | bus.req;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            wait_cnt_q <= '0;
            grant_q    <= '0;
            cv_bcd_q   <= '0;
            bin_q      <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            wait_cnt_q <= wait_cnt_d;
            grant_q    <= grant_d;
            cv_bcd_q   <= cv_bcd_d;
            bin_q      <= bin_d;
        end
    end

    assign bus.ack       = ack_w;
    assign bus.err       = err_w;
    assign bus.bin_out   = bin_q;
    assign bus.grant_id  = grant_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.cv_init   = cv_init_w;
    assign bus.cv_bcd    = cv_bcd_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_bcd2bin_arbiter.sv
// Directed bench for bcd2bin_arbiter: the bench plays both the requesters and the converter.
// All expected values in the vectors below are computed by hand.
module tb_bcd2bin_arbiter;
    import bcd2bin_arb_pkg::*;

    localparam int N_REQ   = 4;
    localparam int BCD_W   = 12;
    localparam int BIN_W   = 10;
    localparam int TIMEOUT = 63;
    localparam int ID_W    = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [ID_W-1:0] exp_q[$];

    bcd2bin_arbiter_if #(.N_REQ(N_REQ), .BCD_W(BCD_W), .BIN_W(BIN_W), .ID_W(ID_W)) bus ();

    bcd2bin_arbiter #(
        .N_REQ(N_REQ), .BCD_W(BCD_W), .BIN_W(BIN_W), .TIMEOUT(TIMEOUT), .ID_W(ID_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [BCD_W-1:0] v);
        bus.bcd_in[i*BCD_W +: BCD_W] = v;
    endtask

    task automatic pulse_req(input logic [N_REQ-1:0] mask);
        bus.req = mask;
        tick();
        bus.req = '0;
    endtask

    task automatic wait_for_init(output int lat, output bit found);
        lat   = 0;
        found = 1'b0;
        while (!found && lat < 20) begin
            if (bus.cv_init) found = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
    endtask

    // One converter transaction: done arrives after 'delay' extra WAIT cycles.
    task automatic serve(input string tag, input int lat_exp, input logic [BCD_W-1:0] exp_bcd,
                         input logic [BIN_W-1:0] result, input int delay,
                         input logic [N_REQ-1:0] midreq, input logic [N_REQ-1:0] rereq);
        int lat;
        bit found;
        logic [ID_W-1:0] id;
        logic [N_REQ-1:0] oh;
        id = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        oh = '0;
        oh[id] = 1'b1;
        wait_for_init(lat, found);
        check({tag, "_init_seen"}, 32'(found), 32'd1);
        if (!found) return;
        if (lat_exp >= 0) check({tag, "_latency"}, lat, lat_exp);
        check({tag, "_grant"}, 32'(bus.grant_id), 32'(id));
        check({tag, "_cv_bcd"}, 32'(bus.cv_bcd), 32'(exp_bcd));
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        bus.req = midreq;
        tick();
        bus.req = '0;
        check({tag, "_init_one"}, 32'(bus.cv_init), 32'd0);
        repeat (delay) tick();
        bus.cv_done = 1'b1;
        bus.cv_bin  = result;
        tick();
        bus.cv_done = 1'b0;
        bus.cv_bin  = '0;
        check({tag, "_ack"}, 32'(bus.ack), 32'(oh));
        check({tag, "_no_err"}, 32'(bus.err), 32'd0);
        check({tag, "_bin"}, 32'(bus.bin_out), 32'(result));
        bus.req = rereq;
        tick();
        bus.req = '0;
        check({tag, "_ack_off"}, 32'(bus.ack), 32'd0);
        check({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic timeout_case(input string tag, input logic [ID_W-1:0] id,
                                input logic [BIN_W-1:0] prev_bin);
        int lat;
        int n;
        bit found;
        bit ack_seen;
        logic [N_REQ-1:0] oh;
        oh = '0;
        oh[id] = 1'b1;
        wait_for_init(lat, found);
        check({tag, "_init_seen"}, 32'(found), 32'd1);
        if (!found) return;
        check({tag, "_grant"}, 32'(bus.grant_id), 32'(id));
        n = 0;
        ack_seen = 1'b0;
        while (bus.err == '0 && n < 100) begin
            tick();
            n++;
            if (bus.ack != '0) ack_seen = 1'b1;
        end
        check({tag, "_cycles"}, n, 65);
        check({tag, "_err"}, 32'(bus.err), 32'(oh));
        check({tag, "_no_ack"}, 32'(ack_seen), 32'd0);
        check({tag, "_bin_kept"}, 32'(bus.bin_out), 32'(prev_bin));
        tick();
        check({tag, "_err_off"}, 32'(bus.err), 32'd0);
    endtask

    // Directed sequence
    initial begin
        int lat;
        bit found;
        bus.req     = '0;
        bus.bcd_in  = '0;
        bus.cv_done = 1'b0;
        bus.cv_bin  = '0;
        set_op(0, 12'h001);
        set_op(1, 12'h099);
        set_op(2, 12'h255);
        set_op(3, 12'h999);

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_bin", 32'(bus.bin_out), 32'd0);
        check("rst_grant", 32'(bus.grant_id), 32'd0);
        check("rst_init", 32'(bus.cv_init), 32'd0);
        check("rst_cv_bcd", 32'(bus.cv_bcd), 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        rst = 1'b1;
        tick();

        // Single request: cv_init in cycle 2, ack one cycle after done
        exp_q.push_back(2'd2);
        pulse_req(4'b0100);
        check("single_c1_busy", 32'(bus.busy), 32'd0);
        serve("single", 1, 12'h255, 10'd255, 2, '0, '0);

        // cv_done outside WAIT is ignored
        bus.cv_done = 1'b1;
        bus.cv_bin  = 10'd123;
        tick();
        bus.cv_done = 1'b0;
        bus.cv_bin  = '0;
        check("idle_done_ack", 32'(bus.ack), 32'd0);
        check("idle_done_bin", 32'(bus.bin_out), 32'd255);
        check("idle_done_busy", 32'(bus.busy), 32'd0);

        // Contention from a fresh reset: order 0,1,2,3
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        set_op(2, 12'h512);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        pulse_req(4'b1111);
        serve("cont0", 1, 12'h001, 10'd1, 0, '0, '0);
        serve("cont1", 1, 12'h099, 10'd99, 3, '0, '0);
        serve("cont2", 1, 12'h512, 10'd512, 1, '0, '0);
        serve("cont3", 1, 12'h999, 10'd999, 5, '0, '0);

        // rr_ptr wrapped to 0, so 0 beats 3
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd3);
        pulse_req(4'b1001);
        serve("ptr0", 1, 12'h001, 10'd1, 0, '0, '0);
        serve("ptr3", 1, 12'h999, 10'd999, 0, '0, '0);

        // Fairness: serve 1, then requests 0 and 2 arrive; 2 goes first
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd0);
        pulse_req(4'b0010);
        serve("fair1", 1, 12'h099, 10'd99, 2, 4'b0101, '0);
        serve("fair2", 1, 12'h512, 10'd512, 0, '0, '0);
        serve("fair0", 1, 12'h001, 10'd1, 0, '0, '0);

        // Timeout on 1, then 3 served normally
        pulse_req(4'b1010);
        timeout_case("tmo1", 2'd1, 10'd1);
        exp_q.push_back(2'd3);
        serve("after_tmo3", -1, 12'h999, 10'd999, 1, '0, '0);

        // Done in the cycle wait_cnt reaches TIMEOUT wins over the timeout
        exp_q.push_back(2'd2);
        pulse_req(4'b0100);
        serve("tie", 1, 12'h512, 10'd512, 63, '0, '0);

        // Re-request in the ack cycle re-queues requester 1
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd1);
        pulse_req(4'b0010);
        serve("rereq_a", 1, 12'h099, 10'd99, 0, '0, 4'b0010);
        serve("rereq_b", 1, 12'h099, 10'd99, 0, '0, '0);

        // Asynchronous reset in the middle of WAIT
        pulse_req(4'b0001);
        wait_for_init(lat, found);
        check("rstmid_init_seen", 32'(found), 32'd1);
        tick();
        check("rstmid_in_wait", 32'(bus.dbg_state), 32'(ST_WAIT));
        #2;
        rst = 1'b0;
        #1;
        check("rstmid_busy", 32'(bus.busy), 32'd0);
        check("rstmid_ack", 32'(bus.ack), 32'd0);
        check("rstmid_err", 32'(bus.err), 32'd0);
        check("rstmid_bin", 32'(bus.bin_out), 32'd0);
        check("rstmid_grant", 32'(bus.grant_id), 32'd0);
        check("rstmid_init", 32'(bus.cv_init), 32'd0);
        check("rstmid_cv_bcd", 32'(bus.cv_bcd), 32'd0);
        tick();
        rst = 1'b1;
        repeat (4) tick();
        check("rstmid_pending_clr_busy", 32'(bus.busy), 32'd0);
        check("rstmid_pending_clr_init", 32'(bus.cv_init), 32'd0);

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
